// File: rtl/sram_req_arbiter.sv
// Round-robin arbiter granting one of four SRAM requesters at a time (IDLE/WAIT/DONE).
// Optional hint timeout is compiled in with `define SRAM_ARB_TIMEOUT_EN.
module sram_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       fifo_i_full,
  input  logic       fifo_i_empty,
  input  logic       fifo_o_full,
  input  logic       fifo_o_empty,
  input  logic       slave_hint,
  input  logic       master_hint,
  input  logic       err_clr,
  output logic [3:0] sram_req,
  output logic [3:0] gnt,
  output logic [3:0] done,
  output logic       busy,
  output logic       timeout_err,
  output logic [1:0] state_dbg
);

  // Handshake: a requester holds req; gnt stays high from selection through the DONE
  // cycle, done pulses once on completion; sram_req drops on completion or timeout.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] last;
  logic [3:0] blocked;
  logic [3:0] eligible;
  logic [1:0] cand;
  logic [1:0] win_idx;
  logic       win_vld;
  logic       hint_hit;

  assign blocked   = {fifo_i_empty, fifo_o_full, fifo_o_empty, fifo_i_full};
  assign eligible  = req & ~blocked;
  // last holds the in-flight index during WAIT/DONE, so it also selects the hint.
  assign hint_hit  = last[1] ? master_hint : slave_hint;
  assign state_dbg = state;

  always_comb begin
    win_vld = 1'b0;
    win_idx = last;
    cand    = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!win_vld && eligible[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef SRAM_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_hit;
  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg  = err_clr ^ TIMEOUT_CYCLES[0];
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      sram_req <= '0;
      gnt      <= '0;
      done     <= '0;
      busy     <= 1'b0;
      last     <= 2'd3;
`ifdef SRAM_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      done <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
      // A timeout set later in this block overrides the clear.
      if (err_clr) timeout_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            gnt      <= 4'b0001 << win_idx;
            sram_req <= 4'b0001 << win_idx;
            last     <= win_idx;
            busy     <= 1'b1;
            state    <= S_WAIT;
`ifdef SRAM_ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (hint_hit) begin
            sram_req <= '0;
            done     <= gnt;
            state    <= S_DONE;
          end
`ifdef SRAM_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            sram_req    <= '0;
            timeout_err <= 1'b1;
            state       <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        S_DONE: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Randomized transaction bench for sram_req_arbiter against a round-robin reference model.
// Inputs change and outputs are checked on the falling clock edge.
module tb_sram_req_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       fifo_i_full, fifo_i_empty, fifo_o_full, fifo_o_empty;
  logic       slave_hint, master_hint, err_clr;
  logic [3:0] sram_req, gnt, done;
  logic       busy, timeout_err;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int last_m = 3;
  int won;

  always #5 clk = ~clk;

  sram_req_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .fifo_i_full(fifo_i_full), .fifo_i_empty(fifo_i_empty),
    .fifo_o_full(fifo_o_full), .fifo_o_empty(fifo_o_empty),
    .slave_hint(slave_hint), .master_hint(master_hint), .err_clr(err_clr),
    .sram_req(sram_req), .gnt(gnt), .done(done), .busy(busy),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Blocking vector in requester order: i_full, o_empty, o_full, i_empty.
  task automatic set_blk(input logic [3:0] b);
    fifo_i_full  = b[0];
    fifo_o_empty = b[1];
    fifo_o_full  = b[2];
    fifo_i_empty = b[3];
  endtask

  function automatic int pick(input logic [3:0] elig);
    for (int k = 1; k <= 4; k++) begin
      if (elig[(last_m + k) % 4]) return (last_m + k) % 4;
    end
    return -1;
  endfunction

  task automatic set_hints(input int w, input logic exp_h, input logic other_h);
    if (w < 2) begin
      slave_hint = exp_h; master_hint = other_h;
    end else begin
      master_hint = exp_h; slave_hint = other_h;
    end
  endtask

  // Called at a falling edge with the DUT idle. noise: 0 quiet, 1 random input churn
  // and random wrong hints during WAIT, 2 wrong hint held high during WAIT.
  task automatic run_txn(input logic [3:0] r, input logic [3:0] b, input int delay,
                         input int noise, output int w);
    logic [3:0] oh;
    w = pick(r & ~b);
    req = r;
    set_blk(b);
    slave_hint = 1'b0; master_hint = 1'b0;
    @(negedge clk);
    if (w < 0) begin
      chk("idle_gnt", gnt, 0);
      chk("idle_sram_req", sram_req, 0);
      chk("idle_busy", busy, 0);
      return;
    end
    oh = 4'b0001 << w;
    chk("grant", gnt, oh);
    chk("grant_sram_req", sram_req, oh);
    chk("grant_busy", busy, 1);
    chk("grant_done", done, 0);
    last_m = w;
    for (int d = 0; d < delay; d++) begin
      if (noise == 1) begin
        req = 4'($urandom_range(0, 15));
        set_blk(4'($urandom_range(0, 15)));
      end
      set_hints(w, 1'b0, (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      @(negedge clk);
      chk("wait_sram_req", sram_req, oh);
      chk("wait_gnt", gnt, oh);
      chk("wait_done", done, 0);
    end
    set_hints(w, 1'b1, (noise != 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    @(negedge clk);
    chk("done_pulse", done, oh);
    chk("done_sram_req", sram_req, 0);
    chk("done_gnt", gnt, oh);
    chk("done_busy", busy, 1);
    slave_hint = 1'b0; master_hint = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_gnt", gnt, 0);
    chk("post_busy", busy, 0);
    chk("post_sram_req", sram_req, 0);
  endtask

  initial begin
    rst = 1'b1; req = '0; err_clr = 1'b0;
    slave_hint = 1'b0; master_hint = 1'b0;
    set_blk(4'b0000);
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_sram_req", sram_req, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", timeout_err, 0);
    rst = 1'b0;

    // All requesters eligible: rotation starts at 0.
    for (int i = 0; i < 6; i++) begin
      run_txn(4'hF, 4'h0, 1, 0, won);
      chk("rr_order", 8'(won), 8'(i % 4));
    end

    // Single slave write, hint four cycles after grant.
    run_txn(4'b0001, 4'h0, 4, 0, won);
    chk("single_idx", 8'(won), 0);

    // o_empty blocks index 1; adding o_full blocks index 2 as well.
    for (int i = 0; i < 3; i++) begin
      run_txn(4'b0110, 4'b0010, 2, 0, won);
      chk("blocked_idx", 8'(won), 2);
    end
    run_txn(4'b0110, 4'b0110, 0, 0, won);
    repeat (3) begin
      @(negedge clk);
      chk("blocked_busy", busy, 0);
      chk("blocked_gnt", gnt, 0);
    end
    req = 4'b0000;

    // Master read must ignore slave_hint.
    run_txn(4'b1000, 4'h0, 4, 2, won);
    chk("master_idx", 8'(won), 3);

    for (int i = 0; i < 150; i++) begin
      run_txn(4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
              $urandom_range(0, 5), 1, won);
    end

    // Index 1 granted with no hint.
    req = 4'b0010; set_blk(4'h0);
    @(negedge clk);
    chk("nohint_gnt", gnt, 4'b0010);
    last_m = 1;
    req = 4'b0000;
`ifdef SRAM_ARB_TIMEOUT_EN
    err_clr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("tmo_hold", sram_req, 4'b0010);
    end
    @(negedge clk);
    chk("tmo_sram_req", sram_req, 0);
    chk("tmo_err_set", timeout_err, 1);
    chk("tmo_no_done", done, 0);
    err_clr = 1'b0;
    @(negedge clk);
    chk("tmo_sticky", timeout_err, 1);
    chk("tmo_idle_gnt", gnt, 0);
    chk("tmo_idle_done", done, 0);
    err_clr = 1'b1;
    @(negedge clk);
    chk("tmo_err_clr", timeout_err, 0);
    err_clr = 1'b0;
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("hold_sram_req", sram_req, 4'b0010);
      chk("hold_done", done, 0);
    end
    chk("hold_err", timeout_err, 0);
    slave_hint = 1'b1;
    @(negedge clk);
    chk("hold_done_pulse", done, 4'b0010);
    slave_hint = 1'b0;
    @(negedge clk);
    chk("hold_exit_gnt", gnt, 0);
`endif

    // Reset in the middle of an index-2 WAIT.
    req = 4'b0100; set_blk(4'h0);
    @(negedge clk);
    chk("prerst_gnt", gnt, 4'b0100);
    req = 4'b0000;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_sram_req", sram_req, 0);
    chk("async_gnt", gnt, 0);
    chk("async_done", done, 0);
    chk("async_busy", busy, 0);
    chk("async_err", timeout_err, 0);
    @(negedge clk);
    chk("rst_hold_done", done, 0);
    rst = 1'b0;
    last_m = 3;
    run_txn(4'hF, 4'h0, 1, 0, won);
    chk("after_rst_idx", 8'(won), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, range 2..255: maximum cycles to wait for a hint per transaction.
REQ-002 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req  in  4  level requests: [0] slave write, [1] slave read, [2] master write, [3] master read.
REQ-005 SHALL have ports fifo_i_full, fifo_i_empty, fifo_o_full, fifo_o_empty  in  1 each  FIFO status from the SRAM controller.
REQ-006 SHALL have ports slave_hint, master_hint  in  1 each  one-cycle completion pulses from the SRAM controller.
REQ-007 SHALL have port err_clr  in  1  clears timeout_err.
REQ-008 SHALL have port sram_req  out  4  one-hot request to the SRAM controller, same bit order as req.
REQ-009 SHALL have port gnt  out  4  one-hot grant to the winning requester.
REQ-010 SHALL have port done  out  4  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-012 SHALL have port timeout_err  out  1  sticky hint-timeout flag.

Function
REQ-013 SHALL implement states IDLE, WAIT, DONE; all outputs registered.
REQ-014 Eligibility SHALL be eligible = req & ~blocked, with blocked[0]=fifo_i_full, [1]=fifo_o_empty, [2]=fifo_o_full, [3]=fifo_i_empty.
REQ-015 In IDLE, if eligible is nonzero, SHALL select round-robin, searching last+1, last+2, last+3, last (mod 4), where last is the 2-bit index of the previous grant.
REQ-016 On the selecting edge, SHALL set gnt and sram_req to the one-hot winner, update last, clear the timeout counter, and enter WAIT. Latency: request high before edge k gives gnt/sram_req high from cycle k+1.
REQ-017 In WAIT, SHALL hold sram_req and gnt; expected hint is slave_hint for indices 0/1 and master_hint for indices 2/3; the other hint SHALL be ignored.
REQ-018 On the edge where the expected hint is sampled high, SHALL clear sram_req, pulse done[index] for exactly one cycle, and enter DONE.
REQ-019 DONE SHALL last exactly one cycle, then clear gnt and return to IDLE; sram_req is therefore low for at least 2 cycles between transactions.
REQ-020 A requester dropping req during WAIT SHALL NOT abort the transaction; it completes normally.
REQ-021 FIFO status changes after grant SHALL be ignored for the current transaction.
REQ-022 With all requesters continuously eligible, grants SHALL rotate 0,1,2,3,0...; no requester waits more than 3 transactions.
REQ-023 Simultaneous err_clr and timeout-set SHALL leave timeout_err set.

Reset
REQ-024 Asserting rst SHALL immediately force: state IDLE, sram_req=0, gnt=0, done=0, busy=0, timeout_err=0, last=3 (index 0 first), timeout counter=0.
REQ-025 Reset asserted mid-WAIT SHALL drop sram_req at once, with no done pulse; the first arbitration after release SHALL favor index 0.

Configuration
REQ-026 Macro SRAM_ARB_TIMEOUT_EN defined: an 8-bit counter increments each WAIT cycle without the expected hint. At count TIMEOUT_CYCLES the block SHALL clear sram_req, set timeout_err, emit no done pulse, and enter DONE; last still advances.
REQ-027 Macro SRAM_ARB_TIMEOUT_EN undefined: no counter; WAIT persists until the expected hint arrives; timeout_err is constant 0; err_clr is unused.

Verification
REQ-028 Reset, all FIFOs not full/not empty, req=4'b0001, slave_hint 4 cycles after grant -> gnt=sram_req=0001 from the next cycle; done=0001 for one cycle after the hint; busy low 2 cycles after the hint.
REQ-029 req=4'b1111 held, hints returned promptly -> grant order 0,1,2,3,0,1; sram_req low ≥2 cycles between grants.
REQ-030 req=4'b0110, fifo_o_empty=1 -> only index 2 is ever granted; fifo_o_full=1 as well -> no grant; busy stays 0.
REQ-031 Grant index 3, drive only slave_hint -> it is ignored and WAIT is held; then master_hint -> done=1000.
REQ-032 SRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, grant index 1, no hint -> after 8 WAIT cycles sram_req=0, timeout_err=1, done stays 0; err_clr pulse -> timeout_err=0. Undefined macro: same stimulus -> WAIT held for 100 cycles.
REQ-033 rst pulsed during WAIT of index 2 -> all outputs 0 asynchronously; after release with req=4'b1111, first grant is index 0.
